// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single unified RAM port between instruction fetch
// and data accesses. Data normally wins, but a data grant is held back for
// one round after a data access if a fetch is waiting, so neither side
// starves. Each access is bounded by a timeout watchdog. RAM errors and
// timeouts raise a sticky error flag that only reset clears.
module mem_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNTW    = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        ihit,
   output logic        dhit,
   output logic [31:0] iload,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        memerr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DSERV = 2'd1,
      ISERV = 2'd2,
      HIT   = 2'd3
   } arbState_t;

   localparam logic [1:0]      RAM_ACCESS  = 2'd2;
   localparam logic [1:0]      RAM_ERROR   = 2'd3;
   localparam logic [CNTW-1:0] TIMEOUT_CNT = CNTW'(TIMEOUT);

   arbState_t       state;
   logic [CNTW-1:0] count;
   logic            lastD;
   logic            opWrite;
   logic [31:0]     latAddr;
   logic [31:0]     latStore;
   logic            dataReq;

   // A write strobe alone counts as a data request; dREN together with dWEN is a write.
   assign dataReq = dREN | dWEN;

   // Arbitration FSM: grant, serve with error/withdraw/timeout handling, one-cycle hit.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state    <= IDLE;
         count    <= '0;
         lastD    <= 1'b0;
         memerr   <= 1'b0;
         ihit     <= 1'b0;
         dhit     <= 1'b0;
         iload    <= '0;
         dload    <= '0;
         opWrite  <= 1'b0;
         latAddr  <= '0;
         latStore <= '0;
      end else begin
         ihit <= 1'b0;
         dhit <= 1'b0;
         case (state)
            IDLE: begin
               if (dataReq && (!iREN || !lastD)) begin
                  latAddr  <= daddr;
                  latStore <= dstore;
                  opWrite  <= dWEN;
                  count    <= '0;
                  state    <= DSERV;
               end else if (iREN) begin
                  latAddr <= iaddr;
                  count   <= '0;
                  state   <= ISERV;
               end
            end
            DSERV: begin
               if (ramstate == RAM_ERROR) begin
                  memerr <= 1'b1;
                  state  <= IDLE;
               end else if (!dataReq) begin
                  state <= IDLE;
               end else if (ramstate == RAM_ACCESS) begin
                  if (!opWrite) begin
                     dload <= ramload;
                  end
                  dhit  <= 1'b1;
                  lastD <= 1'b1;
                  state <= HIT;
               end else if (count == TIMEOUT_CNT) begin
                  memerr <= 1'b1;
                  state  <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            ISERV: begin
               if (ramstate == RAM_ERROR) begin
                  memerr <= 1'b1;
                  state  <= IDLE;
               end else if (!iREN) begin
                  state <= IDLE;
               end else if (ramstate == RAM_ACCESS) begin
                  iload <= ramload;
                  ihit  <= 1'b1;
                  lastD <= 1'b0;
                  state <= HIT;
               end else if (count == TIMEOUT_CNT) begin
                  memerr <= 1'b1;
                  state  <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            HIT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // RAM port drive: strobes only in serve states; address and store data always show the latches.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = latAddr;
      ramstore = latStore;
      case (state)
         DSERV: begin
            ramWEN = opWrite;
            ramREN = !opWrite;
         end
         ISERV: begin
            ramREN = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
